mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 21 ++
 rtl/mem_access_unit.sv | 129 ++++++++++++
 tb/tb_mem_access_unit.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: FSM state encoding,
// default widths and the access-length helper.
package mem_access_pkg;

    localparam int DEF_ADDR_W        = 5;
    localparam int DEF_DATA_W        = 32;
    localparam int DEF_ACCESS_CYCLES = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } mau_state_e;

    // A configured length of 0 still needs one strobe cycle.
    function automatic int eff_access_cycles(input int cycles);
        return (cycles < 1) ? 1 : cycles;
    endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Single-port memory sequencer: accepts one load/store request, drives a
// setup cycle, holds the memory strobe for a fixed number of cycles,
// then presents the captured data word until the consumer takes it.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    output logic              mem_sigwr,
    output logic              mem_sigon,
    input  logic [DATA_W-1:0] mem_dataout
);

    localparam int              ACC_N    = eff_access_cycles(ACCESS_CYCLES);
    localparam int              CNT_W    = $clog2(ACC_N + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_N);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mau_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    logic [DATA_W-1:0] rdata_q;

    logic accept;
    logic last_access;

    assign accept      = req_valid && req_ready;
    assign last_access = (state_q == ST_ACCESS) && (cnt_q <= CNT_ONE);

    // State and strobe counter registers; reset forces IDLE immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: the counter is loaded leaving SETUP and counts the
    // remaining strobe cycles down while in ACCESS.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = CNT_LOAD;
            end
            ST_ACCESS: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latches and the memory data register. Address/data only
    // change on accept, so they are stable across SETUP and ACCESS and
    // keep their last value while idle. A store echoes its own write
    // data so the result does not depend on memory write-through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wr_q    <= req_wr;
            end
            if (last_access) begin
                rdata_q <= wr_q ? wdata_q : mem_dataout;
            end
        end
    end

    // Outputs decoded from state; req_ready stays low while reset is held.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_sigwr = 1'b0;
        mem_sigon = 1'b0;
        unique case (state_q)
            ST_IDLE:   req_ready = !rst;
            ST_SETUP:  mem_sigwr = wr_q;
            ST_ACCESS: begin
                mem_sigwr = wr_q;
                mem_sigon = 1'b1;
            end
            ST_DONE:   rsp_valid = 1'b1;
            default:   ;
        endcase
    end

    assign mem_addr   = addr_q;
    assign mem_datain = wdata_q;
    assign rsp_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one unit with ACCESS_CYCLES=1 backed
// by a small RAM model, plus a pair (ACCESS_CYCLES=3 and 0) driven in
// lockstep for strobe-length and reset checks. Latencies are reported as
// the index of the first rising edge (relative to the accept edge) at
// which rsp_valid is sampled high.
module tb_mem_access_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    // ---------------- unit A (ACCESS_CYCLES = 1) ----------------
    logic        a_req_valid, a_req_ready, a_req_wr;
    logic [4:0]  a_req_addr;
    logic [31:0] a_req_wdata;
    logic        a_rsp_valid, a_rsp_ready;
    logic [31:0] a_rsp_rdata;
    logic [4:0]  a_addr;
    logic [31:0] a_datain, a_dout;
    logic        a_sigwr, a_sigon;

    logic [31:0] memA [32];
    logic        pre_we;
    logic [4:0]  pre_addr;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) memA[pre_addr] <= pre_data;
        else if (a_sigon && a_sigwr) memA[a_addr] <= a_datain;
    end
    assign a_dout = memA[a_addr];

    mem_access_unit #(.ADDR_W(5), .DATA_W(32), .ACCESS_CYCLES(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wr(a_req_wr),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
        .mem_addr(a_addr), .mem_datain(a_datain), .mem_sigwr(a_sigwr),
        .mem_sigon(a_sigon), .mem_dataout(a_dout)
    );

    // ---------------- units B3 / B0 share request inputs ----------------
    logic        b_req_valid, b_req_wr, b_rsp_ready;
    logic [4:0]  b_req_addr;
    logic [31:0] b_req_wdata;

    logic        b3_req_ready, b3_rsp_valid, b3_sigwr, b3_sigon;
    logic [31:0] b3_rsp_rdata, b3_datain, b3_dout;
    logic [4:0]  b3_addr;
    logic        b0_req_ready, b0_rsp_valid, b0_sigwr, b0_sigon;
    logic [31:0] b0_rsp_rdata, b0_datain, b0_dout;
    logic [4:0]  b0_addr;

    // Read-only pattern memories: word = C0DE_00xx with xx = address.
    assign b3_dout = {16'hC0DE, 11'd0, b3_addr};
    assign b0_dout = {16'hC0DE, 11'd0, b0_addr};

    mem_access_unit #(.ADDR_W(5), .DATA_W(32), .ACCESS_CYCLES(3)) u_dut_b3 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b3_req_ready), .req_wr(b_req_wr),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b3_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b3_rsp_rdata),
        .mem_addr(b3_addr), .mem_datain(b3_datain), .mem_sigwr(b3_sigwr),
        .mem_sigon(b3_sigon), .mem_dataout(b3_dout)
    );

    mem_access_unit #(.ADDR_W(5), .DATA_W(32), .ACCESS_CYCLES(0)) u_dut_b0 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b0_req_ready), .req_wr(b_req_wr),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b0_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b0_rsp_rdata),
        .mem_addr(b0_addr), .mem_datain(b0_datain), .mem_sigwr(b0_sigwr),
        .mem_sigon(b0_sigon), .mem_dataout(b0_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request to unit A, wait for the accept edge, then observe
    // until rsp_valid (bounded). Leaves rsp_ready low and the unit in DONE.
    task automatic issue_a(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                           output int lat, output int son, output bit wr_seen,
                           output bit unstable);
        int          k;
        bit          have_ref;
        logic [4:0]  a0;
        logic [31:0] d0;
        a_req_valid = 1'b1;
        a_req_wr    = wr;
        a_req_addr  = addr;
        a_req_wdata = wd;
        a_rsp_ready = 1'b0;
        k = 0;
        while (!a_req_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        lat = 0; son = 0; wr_seen = 1'b0; unstable = 1'b0; have_ref = 1'b0;
        a0 = '0; d0 = '0;
        while (!a_rsp_valid && lat < 20) begin
            if (a_sigwr) wr_seen = 1'b1;
            if (a_sigon) begin
                son++;
                if (have_ref && (a_addr !== a0 || a_datain !== d0)) unstable = 1'b1;
                a0 = a_addr; d0 = a_datain; have_ref = 1'b1;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (a_sigwr) wr_seen = 1'b1;
        lat = lat + 1;
    endtask

    task automatic finish_a();
        a_rsp_ready = 1'b1;
        @(posedge clk); #1;
        a_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (a_req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%0b exp=0", a_req_ready); end
        total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0b exp=0", a_rsp_valid); end
        total++; if ({a_sigon, a_sigwr} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b exp=00", {a_sigon, a_sigwr}); end
        total++; if (a_addr !== 5'd0 || a_datain !== 32'd0) begin bad++; $display("FAIL reset_mem_bus got=%0h/%0h exp=0/0", a_addr, a_datain); end
        total++; if (a_rsp_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%0h exp=0", a_rsp_rdata); end
        rst = 1'b0;
        #1;
        total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%0b exp=1", a_req_ready); end
        total++; if (b3_req_ready !== 1'b1 || b0_req_ready !== 1'b1) begin bad++; $display("FAIL reset_release_b got=%b exp=11", {b3_req_ready, b0_req_ready}); end
    endtask

    task automatic test_load();
        int lat, son; bit ws, us;
        pre_we = 1'b1; pre_addr = 5'd3; pre_data = 32'h0000_00AB;
        @(posedge clk); #1;
        pre_we = 1'b0;
        issue_a(1'b0, 5'd3, 32'h0, lat, son, ws, us);
        total++; if (lat != 3) begin bad++; $display("FAIL load_latency got=%0d exp=3", lat); end
        total++; if (son != 1) begin bad++; $display("FAIL load_sigon_cycles got=%0d exp=1", son); end
        total++; if (a_rsp_rdata !== 32'h0000_00AB) begin bad++; $display("FAIL load_rdata got=%0h exp=ab", a_rsp_rdata); end
        total++; if (ws !== 1'b0) begin bad++; $display("FAIL load_sigwr got=%0b exp=0", ws); end
        total++; if (a_req_ready !== 1'b0 || a_sigon !== 1'b0) begin bad++; $display("FAIL load_done_outputs got=%b exp=00", {a_req_ready, a_sigon}); end
        finish_a();
        total++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin bad++; $display("FAIL load_release got=%b exp=01", {a_rsp_valid, a_req_ready}); end
        total++; if (a_addr !== 5'd3) begin bad++; $display("FAIL idle_addr_hold got=%0h exp=3", a_addr); end
    endtask

    task automatic test_store_load();
        int lat, son; bit ws, us;
        issue_a(1'b1, 5'd31, 32'hDEAD_BEEF, lat, son, ws, us);
        total++; if (a_rsp_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL store_echo got=%0h exp=deadbeef", a_rsp_rdata); end
        total++; if (ws !== 1'b1 || son != 1) begin bad++; $display("FAIL store_strobes got=%0b/%0d exp=1/1", ws, son); end
        total++; if (us !== 1'b0) begin bad++; $display("FAIL store_bus_stable got=%0b exp=0", us); end
        total++; if (a_sigwr !== 1'b0) begin bad++; $display("FAIL store_done_sigwr got=%0b exp=0", a_sigwr); end
        finish_a();
        issue_a(1'b0, 5'd31, 32'h0, lat, son, ws, us);
        total++; if (a_rsp_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL reload_rdata got=%0h exp=deadbeef", a_rsp_rdata); end
        total++; if (ws !== 1'b0) begin bad++; $display("FAIL reload_sigwr got=%0b exp=0", ws); end
        finish_a();
    endtask

    task automatic test_backpressure();
        int lat, son; bit ws, us;
        bit stall_bad;
        issue_a(1'b0, 5'd3, 32'h0, lat, son, ws, us);
        stall_bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'h0000_00AB ||
                a_req_ready !== 1'b0 || a_sigon !== 1'b0) stall_bad = 1'b1;
        end
        total++; if (stall_bad) begin bad++; $display("FAIL stall_hold got=%b/%0h exp=1/ab", {a_rsp_valid, a_req_ready, a_sigon}, a_rsp_rdata); end
        a_rsp_ready = 1'b1;
        @(posedge clk); #1;
        a_rsp_ready = 1'b0;
        total++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin bad++; $display("FAIL stall_exit got=%b exp=01", {a_rsp_valid, a_req_ready}); end
    endtask

    task automatic test_back_to_back();
        int lat, son; bit ws, us;
        int k;
        issue_a(1'b0, 5'd31, 32'h0, lat, son, ws, us);
        a_req_valid = 1'b1; a_req_wr = 1'b0; a_req_addr = 5'd3; a_rsp_ready = 1'b1;
        @(posedge clk); #1;
        a_rsp_ready = 1'b0;
        total++; if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin bad++; $display("FAIL bubble got=%b exp=10", {a_req_ready, a_rsp_valid}); end
        @(posedge clk); #1;
        total++; if (a_req_ready !== 1'b0 || a_addr !== 5'd3) begin bad++; $display("FAIL held_accept got=%b/%0h exp=0/3", a_req_ready, a_addr); end
        a_req_addr = 5'd9;
        @(posedge clk); #1;
        total++; if (a_addr !== 5'd3) begin bad++; $display("FAIL busy_ignore got=%0h exp=3", a_addr); end
        a_req_valid = 1'b0;
        k = 0;
        while (!a_rsp_valid && k < 20) begin @(posedge clk); #1; k++; end
        total++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'h0000_00AB) begin bad++; $display("FAIL b2b_rdata got=%0b/%0h exp=1/ab", a_rsp_valid, a_rsp_rdata); end
        finish_a();
    endtask

    task automatic test_access_cycles();
        int lat3, lat0, son3, son0;
        b_req_valid = 1'b1; b_req_wr = 1'b0; b_req_addr = 5'd5; b_req_wdata = 32'h0; b_rsp_ready = 1'b0;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        lat3 = -1; lat0 = -1; son3 = 0; son0 = 0;
        for (int k = 0; k < 20; k++) begin
            if (b3_sigon) son3++;
            if (b0_sigon) son0++;
            if (b3_rsp_valid && lat3 < 0) lat3 = k + 1;
            if (b0_rsp_valid && lat0 < 0) lat0 = k + 1;
            if (lat3 >= 0 && lat0 >= 0) break;
            @(posedge clk); #1;
        end
        total++; if (son3 != 3) begin bad++; $display("FAIL ac3_sigon got=%0d exp=3", son3); end
        total++; if (lat3 != 5) begin bad++; $display("FAIL ac3_latency got=%0d exp=5", lat3); end
        total++; if (son0 != 1) begin bad++; $display("FAIL ac0_sigon got=%0d exp=1", son0); end
        total++; if (lat0 != 3) begin bad++; $display("FAIL ac0_latency got=%0d exp=3", lat0); end
        total++; if (b3_rsp_rdata !== 32'hC0DE_0005 || b0_rsp_rdata !== 32'hC0DE_0005) begin bad++; $display("FAIL ac_rdata got=%0h/%0h exp=c0de0005", b3_rsp_rdata, b0_rsp_rdata); end
        b_rsp_ready = 1'b1;
        @(posedge clk); #1;
        b_rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        b_req_valid = 1'b1; b_req_wr = 1'b1; b_req_addr = 5'd7; b_req_wdata = 32'h1234_5678; b_rsp_ready = 1'b1;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if ({b3_sigon, b3_sigwr} !== 2'b11) begin bad++; $display("FAIL mid_access_strobes got=%b exp=11", {b3_sigon, b3_sigwr}); end
        #2 rst = 1'b1;
        #1;
        total++; if ({b3_sigon, b3_sigwr} !== 2'b00) begin bad++; $display("FAIL async_drop got=%b exp=00", {b3_sigon, b3_sigwr}); end
        total++; if (b3_rsp_valid !== 1'b0 || b3_req_ready !== 1'b0) begin bad++; $display("FAIL in_reset_outputs got=%b exp=00", {b3_rsp_valid, b3_req_ready}); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++; if (b3_req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%0b exp=1", b3_req_ready); end
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (b3_rsp_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL abandoned_rsp got=%0b exp=0", seen); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1;
        a_req_valid = 1'b0; a_req_wr = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_wr = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        test_reset();
        test_load();
        test_store_load();
        test_backpressure();
        test_back_to_back();
        test_access_cycles();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
